// File: rtl/ifetch_queue.sv
// ============================================================================
//  Module   : ifetch_queue
//  Brief    : Instruction fetch queue. Fetches one word per cycle from a
//             combinational instruction memory into a small FIFO feeding
//             decode, with branch redirect flush. Optional macro
//             IFETCH_QUEUE_BYPASS_EN adds a zero-latency empty-queue bypass.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rd,
    input  logic                     branch_valid,
    input  logic [31:0]              branch_target,
    output logic                     instr_valid,
    output logic [31:0]              instr,
    output logic [31:0]              instr_pc,
    input  logic                     instr_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    // Fetch PC kept as a word address so the low two bits are always zero
    logic [29:0]          r_fpc_w;
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_CNT_W-1:0]   r_count;

    logic [29:0]          r_mem_pc  [DEPTH];
    logic [31:0]          r_mem_ins [DEPTH];

    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_advance;
    logic                 w_bypass_take;
    logic [31:0]          w_head_pc;
    logic [31:0]          w_head_ins;
    logic                 w_unused;

    assign w_unused   = ^branch_target[1:0];

    assign imem_addr  = {r_fpc_w, 2'b00};
    assign count      = r_count;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_FULL);
    assign w_head_pc  = {r_mem_pc[r_rptr], 2'b00};
    assign w_head_ins = r_mem_ins[r_rptr];

`ifdef IFETCH_QUEUE_BYPASS_EN
    logic w_bypass;

    assign w_bypass      = w_empty & ~branch_valid;
    assign w_bypass_take = w_bypass & instr_ready;

    always_comb begin
        instr_valid = ~branch_valid & ~w_empty;
        instr       = '0;
        instr_pc    = '0;
        if (!w_empty) begin
            instr    = w_head_ins;
            instr_pc = w_head_pc;
        end else if (w_bypass) begin
            instr_valid = 1'b1;
            instr       = imem_rd;
            instr_pc    = imem_addr;
        end
    end
`else
    assign w_bypass_take = 1'b0;

    always_comb begin
        instr_valid = ~branch_valid & ~w_empty;
        instr       = '0;
        instr_pc    = '0;
        if (!w_empty) begin
            instr    = w_head_ins;
            instr_pc = w_head_pc;
        end
    end
`endif

    // A bypassed word is consumed straight from memory, so it never occupies a slot
    assign w_pop     = instr_valid & instr_ready & ~w_empty;
    assign w_push    = ~branch_valid & (~w_full | w_pop) & ~w_bypass_take;
    assign w_advance = w_push | w_bypass_take;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fpc_w <= RESET_PC[31:2];
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (branch_valid) begin
            r_fpc_w <= branch_target[31:2];
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_advance) begin
                r_fpc_w <= r_fpc_w + 30'd1;
            end
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage needs no reset: count gates every read of it
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wptr]  <= r_fpc_w;
            r_mem_ins[r_wptr] <= imem_rd;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ifetch_queue.sv
// ============================================================================
//  Module   : tb_ifetch_queue
//  Brief    : Self-checking bench for ifetch_queue with a queue-based model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ifetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFETCH_QUEUE_BYPASS_EN
    localparam logic [31:0] c_BYP = 32'd4;
    localparam logic        c_BYP_VALID = 1'b1;
`else
    localparam logic [31:0] c_BYP = 32'd0;
    localparam logic        c_BYP_VALID = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    reset;
    logic [31:0]             imem_addr;
    logic [31:0]             imem_rd;
    logic                    branch_valid;
    logic [31:0]             branch_target;
    logic                    instr_valid;
    logic [31:0]             instr;
    logic [31:0]             instr_pc;
    logic                    instr_ready;
    logic [$clog2(DEPTH):0]  count;

    always #5 clk = ~clk;

    assign imem_rd = imem_addr + 32'h1000;

    ifetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_rd       (imem_rd),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .count         (count)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_fpc;
    bit          check_en;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advance on a rising edge, from the inputs present before the edge
    task automatic model_step();
        int   sz;
        bit   take;
        bit   pop;
        bit   push;
        ent_t e;
        if (reset) begin
            q.delete();
            m_fpc = RESET_PC;
            return;
        end
        if (branch_valid) begin
            q.delete();
            m_fpc = {branch_target[31:2], 2'b00};
            return;
        end
        sz   = q.size();
        take = c_BYP_VALID && (sz == 0) && instr_ready;
        pop  = (sz != 0) && instr_ready;
        push = !take && ((sz < DEPTH) || pop);
        if (pop) void'(q.pop_front());
        if (push) begin
            e.pc  = m_fpc;
            e.ins = m_fpc + 32'h1000;
            q.push_back(e);
        end
        if (push || take) m_fpc = m_fpc + 32'd4;
    endtask

    always @(negedge clk) begin
        if (check_en) begin : cmp
            logic        ev;
            logic [31:0] ei;
            logic [31:0] ep;
            ev = 1'b0;
            ei = '0;
            ep = '0;
            if (q.size() != 0) begin
                ev = !branch_valid;
                ei = q[0].ins;
                ep = q[0].pc;
            end else if (c_BYP_VALID && !branch_valid) begin
                ev = 1'b1;
                ei = m_fpc + 32'h1000;
                ep = m_fpc;
            end
            check("imem_addr", imem_addr, m_fpc);
            check("count", 32'(count), 32'(q.size()));
            check("instr_valid", 32'(instr_valid), 32'(ev));
            if (ev || q.size() == 0) begin
                check("instr", instr, ei);
                check("instr_pc", instr_pc, ep);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        check_en     = 1'b0;
        reset        = 1'b1;
        branch_valid = 1'b0;
        q.delete();
        m_fpc = RESET_PC;
        tick();
        reset    = 1'b0;
        check_en = 1'b1;
    endtask

    initial begin
        reset         = 1'b1;
        branch_valid  = 1'b0;
        branch_target = '0;
        instr_ready   = 1'b1;
        check_en      = 1'b0;
        m_fpc         = RESET_PC;
        q.delete();

        // Reset values, before any clock edge
        #2;
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", instr_pc, 32'd0);
        tick();
        tick();
        reset    = 1'b0;
        check_en = 1'b1;

        // Streaming with ready held high
        at_neg();
        check("lat_valid", 32'(instr_valid), 32'(c_BYP_VALID));
        for (int i = 0; i < 6; i++) begin
            tick();
            at_neg();
            check("seq_pc", instr_pc, 32'(i * 4) + c_BYP);
            check("seq_instr", instr, 32'(i * 4) + c_BYP + 32'h1000);
        end

        // Fill to full, then drain in order with no gap
        do_reset();
        instr_ready = 1'b0;
        repeat (8) tick();
        at_neg();
        check("full_count", 32'(count), 32'd4);
        check("full_addr", imem_addr, 32'h10);
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("drain_pc", instr_pc, 32'(i * 4));
            check("drain_count", 32'(count), 32'd4);
            tick();
            at_neg();
        end

        // Redirect with two entries queued
        do_reset();
        instr_ready = 1'b0;
        tick();
        tick();
        at_neg();
        check("pre_br_count", 32'(count), 32'd2);
        branch_valid  = 1'b1;
        branch_target = 32'h0000_0203;
        #1;
        check("br_valid", 32'(instr_valid), 32'd0);
        tick();
        branch_valid = 1'b0;
        at_neg();
        check("br_count", 32'(count), 32'd0);
        check("br_addr", imem_addr, 32'h0000_0200);
        instr_ready = 1'b1;
        tick();
        at_neg();
        check("br_pc", instr_pc, 32'h0000_0200 + c_BYP);

        // Fetch PC wraps past the top of the address space
        branch_valid  = 1'b1;
        branch_target = 32'hFFFF_FFF8;
        tick();
        branch_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            at_neg();
            check("wrap_pc", instr_pc, 32'hFFFF_FFF8 + 32'(i * 4) + c_BYP);
        end

        // Flush wins over pop on a full queue
        instr_ready = 1'b0;
        repeat (6) tick();
        at_neg();
        check("pre_flush_count", 32'(count), 32'd4);
        instr_ready   = 1'b1;
        branch_valid  = 1'b1;
        branch_target = 32'h0000_0040;
        tick();
        branch_valid = 1'b0;
        at_neg();
        check("flush_count", 32'(count), 32'd0);
        check("flush_addr", imem_addr, 32'h0000_0040);

        // Asynchronous reset between edges
        do_reset();
        instr_ready = 1'b0;
        repeat (3) tick();
        at_neg();
        check("pre_arst_count", 32'(count), 32'd3);
        #2;
        check_en = 1'b0;
        reset    = 1'b1;
        q.delete();
        m_fpc = RESET_PC;
        #1;
        check("arst_valid", 32'(instr_valid), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_addr", imem_addr, RESET_PC);
        tick();
        reset       = 1'b0;
        check_en    = 1'b1;
        instr_ready = 1'b1;
        tick();
        at_neg();
        check("resume_pc", instr_pc, RESET_PC + c_BYP);
        check("resume_valid", 32'(instr_valid), 32'd1);

        // Mixed ready/redirect traffic, checked cycle by cycle against the model
        for (int i = 0; i < 40; i++) begin
            instr_ready   = ((i % 5) != 1) && ((i % 7) != 3);
            branch_valid  = ((i % 11) == 6);
            branch_target = 32'h100 * 32'(i) + 32'h2;
            tick();
        end
        branch_valid = 1'b0;
        at_neg();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the number of queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, the fetch address after reset (word aligned).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port imem_addr  output  32  byte address driven to the instruction memory read port.
REQ-006 SHALL have port imem_rd  input  32  instruction word returned combinationally for imem_addr.
REQ-007 SHALL have port branch_valid  input  1  redirect request from execute.
REQ-008 SHALL have port branch_target  input  32  redirect byte address.
REQ-009 SHALL have port instr_valid  output  1  queue head holds a valid instruction.
REQ-010 SHALL have port instr  output  32  head instruction word.
REQ-011 SHALL have port instr_pc  output  32  byte address of head instruction.
REQ-012 SHALL have port instr_ready  input  1  decode accepts the head this cycle.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-014 SHALL hold fetch PC fpc and drive imem_addr = fpc combinationally, always with bits [1:0] = 2'b00.
REQ-015 SHALL pop the head on a clock edge when instr_valid and instr_ready are both 1 (fire).
REQ-016 SHALL push {fpc, imem_rd} at the tail and advance fpc by 4 on an edge when count < DEPTH, or when count == DEPTH and a pop fires the same cycle.
REQ-017 SHALL not push and shall hold fpc when count == DEPTH and no pop fires (full stall).
REQ-018 SHALL update count as +1 on push only, -1 on pop only, unchanged on push+pop.
REQ-019 SHALL wrap fpc from 32'hFFFF_FFFC to 32'h0000_0000 with no side effect.
REQ-020 SHALL wrap internal read/write pointers modulo DEPTH.
REQ-021 SHALL drive instr_valid = (count != 0) and, when count == 0, drive instr = 0 and instr_pc = 0.
REQ-022 SHALL, on an edge with branch_valid = 1, set count and both pointers to 0 and load fpc with {branch_target[31:2], 2'b00}; no push occurs that cycle.
REQ-023 SHALL force instr_valid = 0 combinationally while branch_valid = 1, so no pop fires during a redirect.
REQ-024 SHALL deliver a fetched instruction on instr_valid one cycle after it is pushed (min. fetch-to-decode latency 1 cycle).
REQ-025 SHALL sustain one instruction per cycle when instr_ready is held 1 and no redirect occurs.
REQ-026 SHALL keep each entry's instr_pc equal to the fpc at which it was fetched, in program order.

Reset
REQ-027 SHALL, while reset = 1 and independent of clk, set fpc = RESET_PC, count = 0 and pointers = 0, giving imem_addr = RESET_PC, instr_valid = 0, instr = 0 and instr_pc = 0.
REQ-028 SHALL discard all queued entries when reset asserts mid-operation and resume fetching from RESET_PC on the first edge after deassertion.
REQ-029 SHALL need no reset for entry storage; stale contents are never visible.

Configuration
REQ-030 SHALL, with macro IFETCH_QUEUE_BYPASS_EN defined, present imem_rd/fpc directly on instr/instr_pc with instr_valid = 1 when count == 0 and branch_valid = 0.
REQ-031 SHALL, in that bypass case, skip the push when instr_ready = 1 but still advance fpc by 4 (zero-latency path).
REQ-032 SHALL, without IFETCH_QUEUE_BYPASS_EN, behave exactly per REQ-021 and REQ-024 with no combinational path from imem_rd to instr.

Verification
REQ-033 Reset then release, instr_ready = 1, imem returns addr+32'h1000 -> instr_pc 0,4,8,... on consecutive cycles, instr = 32'h1000,32'h1004,... with first valid 1 cycle after release (0 cycles with bypass).
REQ-034 instr_ready = 0 for 8 cycles from reset -> count reaches 4 (DEPTH) and stays; imem_addr stops at 32'h10; then ready = 1 -> 4 queued entries pc 0..C drain in order, then pc 10 follows with no gap.
REQ-035 Queue at count 2, branch_valid = 1 with target 32'h0000_0203 -> next cycle count = 0, imem_addr = 32'h0000_0200, instr_valid = 0 during the branch cycle; the next instr_pc seen is 32'h200.
REQ-036 Redirect to 32'hFFFF_FFF8, ready = 1 -> instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
REQ-037 Full queue, ready = 1 and branch_valid = 1 same cycle -> no pop, flush wins, count = 0 next cycle.
REQ-038 reset asserted asynchronously between edges with count = 3 -> instr_valid = 0, count = 0 and imem_addr = RESET_PC immediately, before the next edge.
